// File: rtl/mux_nto1_pipe_if.sv
// Valid/ready bus for mux_nto1_pipe: upstream select request in, registered result out.
// master drives the request side and accepts results; slave is the mux itself.
interface mux_nto1_pipe_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
);
    logic [WIDTH*NUM_IN-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        dout;
    logic [SEL_W-1:0]        sel_out;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport master (
        output din, sel, in_valid, out_ready,
        input  in_ready, dout, sel_out, out_valid, sel_err
    );

    modport slave (
        input  din, sel, in_valid, out_ready,
        output in_ready, dout, sel_out, out_valid, sel_err
    );
endinterface

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 mux with valid/ready on both sides and a skid entry for back-pressure.
// Optional MUX_SEL_RANGE_CHECK_EN: out-of-range sel yields data 0 and raises sel_err.
module mux_nto1_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input logic             clk,
    input logic             rst_n,
    mux_nto1_pipe_if.slave  bus
);
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic [WIDTH-1:0] new_data;
    logic             xfer_in, xfer_out;
`ifdef MUX_SEL_RANGE_CHECK_EN
    logic             main_err_q, main_err_d;
    logic             skid_err_q, skid_err_d;
    logic             new_err;
`endif

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.dout      = main_data_q;
    assign bus.sel_out   = main_sel_q;
`ifdef MUX_SEL_RANGE_CHECK_EN
    assign bus.sel_err   = main_err_q;
`else
    assign bus.sel_err   = 1'b0;
`endif

    assign xfer_in  = bus.in_valid && !skid_valid_q;
    assign xfer_out = main_valid_q && bus.out_ready;

    // Input 0 is the fallback, so an unmatched sel never indexes past din.
    always_comb begin
        new_data = bus.din[WIDTH-1:0];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                new_data = bus.din[k*WIDTH +: WIDTH];
            end
        end
`ifdef MUX_SEL_RANGE_CHECK_EN
        new_err = (32'(bus.sel) >= NUM_IN);
        if (new_err) begin
            new_data = '0;
        end
`endif
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
`ifdef MUX_SEL_RANGE_CHECK_EN
        main_err_d   = main_err_q;
        skid_err_d   = skid_err_q;
`endif
        if (!main_valid_q || (xfer_out && !skid_valid_q)) begin
            main_valid_d = xfer_in;
            if (xfer_in) begin
                main_data_d = new_data;
                main_sel_d  = bus.sel;
`ifdef MUX_SEL_RANGE_CHECK_EN
                main_err_d  = new_err;
`endif
            end
        end else if (xfer_out) begin
            // Skid is full here, so in_ready was low and nothing enters this cycle.
            main_data_d  = skid_data_q;
            main_sel_d   = skid_sel_q;
            skid_valid_d = 1'b0;
`ifdef MUX_SEL_RANGE_CHECK_EN
            main_err_d   = skid_err_q;
`endif
        end else if (xfer_in) begin
            skid_valid_d = 1'b1;
            skid_data_d  = new_data;
            skid_sel_d   = bus.sel;
`ifdef MUX_SEL_RANGE_CHECK_EN
            skid_err_d   = new_err;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_sel_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_sel_q   <= main_sel_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
        end
    end

`ifdef MUX_SEL_RANGE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_err_q <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            main_err_q <= main_err_d;
            skid_err_q <= skid_err_d;
        end
    end
`endif
endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: table of per-cycle vectors plus reset and range-check sequences.
module tb_mux_nto1_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_nto1_pipe_if #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) bus1 ();
    mux_nto1_pipe_if #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) bus2 ();

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       iv;
        logic       ordy;
        logic       exp_ov;
        logic       exp_ir;
        logic [7:0] exp_dout;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // Expected outputs are those seen at the negedge before the inputs of the same row apply.
        vecs[0]  = '{sel: 2'd2, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b0, exp_ir: 1'b1, exp_dout: 8'h00, exp_sel: 2'd0};
        vecs[1]  = '{sel: 2'd0, iv: 1'b0, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h33, exp_sel: 2'd2};
        vecs[2]  = '{sel: 2'd0, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b0, exp_ir: 1'b1, exp_dout: 8'h00, exp_sel: 2'd0};
        vecs[3]  = '{sel: 2'd1, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h11, exp_sel: 2'd0};
        vecs[4]  = '{sel: 2'd2, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h22, exp_sel: 2'd1};
        vecs[5]  = '{sel: 2'd3, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h33, exp_sel: 2'd2};
        vecs[6]  = '{sel: 2'd0, iv: 1'b0, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h44, exp_sel: 2'd3};
        vecs[7]  = '{sel: 2'd0, iv: 1'b1, ordy: 1'b0, exp_ov: 1'b0, exp_ir: 1'b1, exp_dout: 8'h00, exp_sel: 2'd0};
        vecs[8]  = '{sel: 2'd1, iv: 1'b1, ordy: 1'b0, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h11, exp_sel: 2'd0};
        vecs[9]  = '{sel: 2'd2, iv: 1'b1, ordy: 1'b0, exp_ov: 1'b1, exp_ir: 1'b0, exp_dout: 8'h11, exp_sel: 2'd0};
        vecs[10] = '{sel: 2'd2, iv: 1'b1, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b0, exp_dout: 8'h11, exp_sel: 2'd0};
        vecs[11] = '{sel: 2'd0, iv: 1'b0, ordy: 1'b1, exp_ov: 1'b1, exp_ir: 1'b1, exp_dout: 8'h22, exp_sel: 2'd1};
        vecs[12] = '{sel: 2'd0, iv: 1'b0, ordy: 1'b1, exp_ov: 1'b0, exp_ir: 1'b1, exp_dout: 8'h00, exp_sel: 2'd0};

        bus1.din       = {8'h44, 8'h33, 8'h22, 8'h11};
        bus1.sel       = 2'd0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        bus2.din       = {8'hcc, 8'hbb, 8'haa};
        bus2.sel       = 2'd0;
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(bus1.out_valid), 32'd0);
        check("reset dout", 32'(bus1.dout), 32'h00);
        check("reset in_ready", 32'(bus1.in_ready), 32'd1);
        check("reset sel_out", 32'(bus1.sel_out), 32'd0);
        check("reset sel_err", 32'(bus1.sel_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d out_valid", i), 32'(bus1.out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d in_ready", i), 32'(bus1.in_ready), 32'(vecs[i].exp_ir));
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d dout", i), 32'(bus1.dout), 32'(vecs[i].exp_dout));
                check($sformatf("vec%0d sel_out", i), 32'(bus1.sel_out), 32'(vecs[i].exp_sel));
                check($sformatf("vec%0d sel_err", i), 32'(bus1.sel_err), 32'd0);
            end
            bus1.sel       = vecs[i].sel;
            bus1.in_valid  = vecs[i].iv;
            bus1.out_ready = vecs[i].ordy;
        end

        // Fill main and skid, then reset asynchronously between clock edges.
        @(negedge clk);
        bus1.sel       = 2'd0;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b0;
        @(negedge clk);
        bus1.sel = 2'd1;
        @(negedge clk);
        check("full out_valid", 32'(bus1.out_valid), 32'd1);
        check("full in_ready", 32'(bus1.in_ready), 32'd0);
        bus1.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus1.out_valid), 32'd0);
        check("async rst in_ready", 32'(bus1.in_ready), 32'd1);
        check("async rst dout", 32'(bus1.dout), 32'h00);
        @(negedge clk);
        rst_n          = 1'b1;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        check("post rst out_valid a", 32'(bus1.out_valid), 32'd0);
        @(negedge clk);
        check("post rst out_valid b", 32'(bus1.out_valid), 32'd0);
        check("post rst in_ready", 32'(bus1.in_ready), 32'd1);

        // Out-of-range sel on the 3-input instance.
        bus2.sel      = 2'd3;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        check("range out_valid", 32'(bus2.out_valid), 32'd1);
        check("range sel_out", 32'(bus2.sel_out), 32'd3);
`ifdef MUX_SEL_RANGE_CHECK_EN
        check("range dout", 32'(bus2.dout), 32'h00);
        check("range sel_err", 32'(bus2.sel_err), 32'd1);
`else
        check("range dout", 32'(bus2.dout), 32'haa);
        check("range sel_err", 32'(bus2.sel_err), 32'd0);
`endif
        bus2.sel = 2'd1;
        @(negedge clk);
        check("inrange dout", 32'(bus2.dout), 32'hbb);
        check("inrange sel_err", 32'(bus2.sel_err), 32'd0);
        bus2.sel = 2'd2;
        @(negedge clk);
        check("inrange2 dout", 32'(bus2.dout), 32'hcc);
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("range idle out_valid", 32'(bus2.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
